load_store_unit: RTL and testbench

// - Execute-stage neighbour: consumes the integer ALU sum (rs1+imm) as effective address for LB/LH/LW/LBU/LHU/SB/SH/SW.
// - Drives a single-outstanding req/ack data-memory port with byte enables.
// - Returns sign/zero-extended load data to writeback.
// - Flags misaligned accesses instead of issuing them.

---
 rtl/riscuinho_pkg.sv | 45 ++++
 rtl/lsu_align.sv | 48 ++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscuinho_pkg.sv
// Shared definitions for the riscuinho core: memory opcodes, LSU op codes and state.
package riscuinho_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned OP_W  = 16;
    localparam int unsigned OPC_W = 6;

    // Opcodes drop the constant-zero MSB of the 7-bit RISC-V major opcode.
    localparam logic [OPC_W-1:0] TYPE_IL = 6'b000011;
    localparam logic [OPC_W-1:0] TYPE_S  = 6'b100011;

    localparam logic [OP_W-1:0] OP_LB  = {7'b0, 3'b000, TYPE_IL};
    localparam logic [OP_W-1:0] OP_LH  = {7'b0, 3'b001, TYPE_IL};
    localparam logic [OP_W-1:0] OP_LW  = {7'b0, 3'b010, TYPE_IL};
    localparam logic [OP_W-1:0] OP_LBU = {7'b0, 3'b100, TYPE_IL};
    localparam logic [OP_W-1:0] OP_LHU = {7'b0, 3'b101, TYPE_IL};
    localparam logic [OP_W-1:0] OP_SB  = {7'b0, 3'b000, TYPE_S};
    localparam logic [OP_W-1:0] OP_SH  = {7'b0, 3'b001, TYPE_S};
    localparam logic [OP_W-1:0] OP_SW  = {7'b0, 3'b010, TYPE_S};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Request payload held on the memory port while mem_req is high.
    typedef struct packed {
        logic             we;
        logic [XLEN-1:0]  addr;
        logic [LANES-1:0] be;
        logic [XLEN-1:0]  wdata;
    } mem_req_t;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store replication, load extraction and alignment check.
module lsu_align
    import riscuinho_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    input  logic [1:0]       addr_lo,
    input  logic [XLEN-1:0]  store_data,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [LANES-1:0] be,
    output logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  load_data,
    output logic             misaligned
);

    logic [2:0]      funct3;
    logic [XLEN-1:0] lane;

    assign funct3 = op[OPC_W +: 3];
    assign lane   = mem_rdata >> {addr_lo, 3'b000};

    // funct3[1:0] encodes access size, funct3[2] selects zero extension.
    always_comb begin
        be         = '0;
        wdata      = '0;
        load_data  = '0;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = funct3[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            end
            2'b01: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                load_data  = funct3[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
                misaligned = addr_lo[0];
            end
            default: begin
                be         = 4'b1111;
                wdata      = store_data;
                load_data  = mem_rdata;
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding req/ack data-memory port with writeback of extended loads.
module load_store_unit
    import riscuinho_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           alu_op,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [4:0]            rd_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  store_done,
    output logic                  misaligned
);

    lsu_state_t            state_q, state_d;
    mem_req_t              req_q, req_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_req_q, mem_req_d;
    logic [OP_W-1:0]       op_q, op_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [4:0]            rd_q, rd_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  store_done_q, store_done_d;
    logic                  misaligned_q, misaligned_d;

    logic                  idle_c;
    logic [OP_W-1:0]       align_op_c;
    logic [1:0]            align_lo_c;
    logic [LANES-1:0]      be_c;
    logic [XLEN-1:0]       wdata_c;
    logic [XLEN-1:0]       load_data_c;
    logic                  misaligned_c;

    // One steering block: decodes the incoming op while idle, the captured op afterwards.
    assign idle_c     = (state_q == IDLE);
    assign align_op_c = idle_c ? alu_op : op_q;
    assign align_lo_c = idle_c ? addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .op         (align_op_c),
        .addr_lo    (align_lo_c),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .be         (be_c),
        .wdata      (wdata_c),
        .load_data  (load_data_c),
        .misaligned (misaligned_c)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        op_d         = op_q;
        addr_lo_d    = addr_lo_q;
        rd_d         = rd_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        wb_valid_d   = 1'b0;
        store_done_d = 1'b0;
        misaligned_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && (is_load(alu_op) || is_store(alu_op))) begin
                    if (misaligned_c) begin
                        misaligned_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        req_d.we    = is_store(alu_op);
                        req_d.addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
                        req_d.be    = be_c;
                        req_d.wdata = wdata_c;
                        op_d        = alu_op;
                        addr_lo_d   = addr[1:0];
                        rd_d        = rd_in;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = RESP;
                    if (req_q.we) begin
                        store_done_d = 1'b1;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_data_c;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_req_d  = (state_d == REQ);
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            in_ready_q   <= 1'b1;
            mem_req_q    <= 1'b0;
            op_q         <= '0;
            addr_lo_q    <= '0;
            rd_q         <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            store_done_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            in_ready_q   <= in_ready_d;
            mem_req_q    <= mem_req_d;
            op_q         <= op_d;
            addr_lo_q    <= addr_lo_d;
            rd_q         <= rd_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            store_done_q <= store_done_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = req_q.we;
    assign mem_addr   = req_q.addr;
    assign mem_be     = req_q.be;
    assign mem_wdata  = req_q.wdata;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign store_done = store_done_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops against a lane-arithmetic model.
module tb_load_store_unit;
    import riscuinho_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        store_done;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_wb_data;
    logic [4:0]  exp_wb_rd;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .addr(addr), .store_data(store_data), .rd_in(rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .store_done(store_done), .misaligned(misaligned)
    );

    // Model: op kinds 0..7 = LB LH LW LBU LHU SB SH SW.
    function automatic logic [15:0] op_of(input int k);
        case (k)
            0: return OP_LB;
            1: return OP_LH;
            2: return OP_LW;
            3: return OP_LBU;
            4: return OP_LHU;
            5: return OP_SB;
            6: return OP_SH;
            default: return OP_SW;
        endcase
    endfunction

    function automatic int size_of(input int k);
        if (k == 0 || k == 3 || k == 5) return 1;
        if (k == 1 || k == 4 || k == 6) return 2;
        return 4;
    endfunction

    function automatic bit m_mis(input int k, input logic [31:0] a);
        return (int'(a[1:0]) % size_of(k)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input int k, input logic [31:0] a);
        int v;
        v = ((1 << size_of(k)) - 1) << int'(a[1:0]);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input int k, input logic [31:0] sd);
        if (size_of(k) == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (size_of(k) == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input int k, input logic [31:0] a, input logic [31:0] rdata);
        logic [31:0] v;
        logic [31:0] mask;
        int nbits;
        if (size_of(k) == 4) return rdata;
        nbits = 8 * size_of(k);
        mask  = (32'd1 << nbits) - 32'd1;
        v     = (rdata >> (8 * int'(a[1:0]))) & mask;
        if (k <= 1 && ((v >> (nbits - 1)) & 32'd1) == 32'd1) v = v | ~mask;
        return v;
    endfunction

    task automatic run_txn(input int k, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdata, input logic [4:0] rd, input int delay,
                           input string tag);
        bit mis;
        bit st;
        mis = m_mis(k, a);
        st  = (k >= 5);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready_idle got %b want 1", tag, in_ready); end
        in_valid = 1'b1; alu_op = op_of(k); addr = a; store_data = sd; rd_in = rd;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_op = $urandom(); addr = $urandom(); store_data = $urandom();
        if (mis) begin
            n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL %s misaligned got %b want 1", tag, misaligned); end
            n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s mis_mem_req got %b want 0", tag, mem_req); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s mis_in_ready got %b want 1", tag, in_ready); end
            @(posedge clk); #1;
            n_checks++; if (misaligned !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL %s mis_after got mis=%b req=%b want 0 0", tag, misaligned, mem_req); end
            return;
        end
        n_checks++; if (mem_req !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL %s req_rise got req=%b rdy=%b want 1 0", tag, mem_req, in_ready); end
        n_checks++; if (mem_we !== st) begin n_fail++; $display("FAIL %s mem_we got %b want %b", tag, mem_we, st); end
        n_checks++; if (mem_addr !== (a & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL %s mem_addr got %h want %h", tag, mem_addr, a & 32'hFFFF_FFFC); end
        n_checks++; if (mem_be !== m_be(k, a)) begin n_fail++; $display("FAIL %s mem_be got %b want %b", tag, mem_be, m_be(k, a)); end
        if (st) begin
            n_checks++; if (mem_wdata !== m_wdata(k, sd)) begin n_fail++; $display("FAIL %s mem_wdata got %h want %h", tag, mem_wdata, m_wdata(k, sd)); end
        end
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            n_checks++; if (mem_req !== 1'b1 || mem_be !== m_be(k, a)) begin n_fail++; $display("FAIL %s req_hold got req=%b be=%b want 1 %b", tag, mem_req, mem_be, m_be(k, a)); end
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = $urandom();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s resp_mem_req got %b want 0", tag, mem_req); end
        n_checks++; if (wb_valid !== !st || store_done !== st) begin n_fail++; $display("FAIL %s resp_pulse got wb=%b sd=%b want %b %b", tag, wb_valid, store_done, !st, st); end
        if (!st) begin
            exp_wb_data = m_load(k, a, rdata);
            exp_wb_rd   = rd;
            n_checks++; if (wb_data !== exp_wb_data || wb_rd !== exp_wb_rd) begin n_fail++; $display("FAIL %s wb got %h/%0d want %h/%0d", tag, wb_data, wb_rd, exp_wb_data, exp_wb_rd); end
        end
        @(posedge clk); #1;
        n_checks++; if (wb_valid !== 1'b0 || store_done !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL %s after_resp got wb=%b sd=%b rdy=%b want 0 0 1", tag, wb_valid, store_done, in_ready); end
        n_checks++; if (wb_data !== exp_wb_data) begin n_fail++; $display("FAIL %s wb_hold got %h want %h", tag, wb_data, exp_wb_data); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; addr = '0; store_data = '0;
        rd_in = '0; mem_rdata = '0; mem_ack = 1'b0;
        exp_wb_data = '0; exp_wb_rd = '0;
        #12;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        n_checks++; if ({mem_req, mem_we, wb_valid, store_done, misaligned} !== 5'b0) begin n_fail++; $display("FAIL reset pulses got %b want 00000", {mem_req, mem_we, wb_valid, store_done, misaligned}); end
        n_checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset mem_fields got %h %b %h want 0", mem_addr, mem_be, mem_wdata); end
        n_checks++; if (wb_rd !== 5'd0 || wb_data !== 32'h0) begin n_fail++; $display("FAIL reset wb_fields got %0d %h want 0", wb_rd, wb_data); end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        run_txn(2, 32'h100, 32'h0, 32'hDEAD_BEEF, 5'd5, 2, "lw_0x100");
    endtask

    task automatic test_lb_lbu();
        run_txn(0, 32'h103, 32'h0, 32'h8011_2233, 5'd7, 1, "lb_0x103");
        run_txn(3, 32'h103, 32'h0, 32'h8011_2233, 5'd8, 1, "lbu_0x103");
    endtask

    task automatic test_sh();
        run_txn(6, 32'h202, 32'h0000_ABCD, 32'h1234_5678, 5'd9, 1, "sh_0x202");
    endtask

    task automatic test_misaligned();
        run_txn(2, 32'h101, 32'h0, 32'h0, 5'd3, 0, "lw_0x101");
        run_txn(6, 32'h203, 32'h1111, 32'h0, 5'd3, 0, "sh_0x203");
    endtask

    task automatic test_ack_same_cycle();
        run_txn(1, 32'h2, 32'h0, 32'h8765_4321, 5'd12, 0, "lh_ack0");
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || store_done !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stray_ack got req=%b wb=%b sd=%b rdy=%b want 0 0 0 1", mem_req, wb_valid, store_done, in_ready); end
            n_checks++; if (wb_data !== exp_wb_data || wb_rd !== exp_wb_rd) begin n_fail++; $display("FAIL stray_ack_wb got %h/%0d want %h/%0d", wb_data, wb_rd, exp_wb_data, exp_wb_rd); end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; alu_op = OP_LW; addr = 32'h300; rd_in = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid req_before got %b want 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid async got req=%b rdy=%b want 0 1", mem_req, in_ready); end
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        exp_wb_data = '0; exp_wb_rd = '0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_checks++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid late_ack got req=%b wb=%b rdy=%b want 0 0 1", mem_req, wb_valid, in_ready); end
        n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid wb_data got %h want 0", wb_data); end
        run_txn(2, 32'h400, 32'h0, 32'h0BAD_F00D, 5'd6, 1, "lw_after_rst");
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b1;
                alu_op = {7'($urandom()), 3'($urandom()), ($urandom_range(0, 1) == 0) ? 6'h13 : 6'h33};
                addr = $urandom();
                @(posedge clk); #1;
                in_valid = 1'b0;
                n_checks++; if (in_ready !== 1'b1 || mem_req !== 1'b0 || misaligned !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rand_nonmem got rdy=%b req=%b mis=%b wb=%b want 1 0 0 0", in_ready, mem_req, misaligned, wb_valid); end
            end else begin
                run_txn(int'($urandom_range(0, 7)), $urandom(), $urandom(), $urandom(),
                        5'($urandom()), int'($urandom_range(0, 3)), "rand");
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misaligned();
        test_ack_same_cycle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
